// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register for the RV32IM 5-stage core: captures decoded operands
// and EX/MEM/WB control each cycle, with hold (STALL) and bubble insert (FLUSH).
module id_ex_pipeline_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ALU_OP_WIDTH   = 5
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      STALL,
  input  logic                      FLUSH,
  input  logic [REG_ADDR_WIDTH-1:0] DEST_REG,
  input  logic [DATA_WIDTH-1:0]     PC_PLUS_4,
  input  logic [DATA_WIDTH-1:0]     READ_DATA1,
  input  logic [DATA_WIDTH-1:0]     READ_DATA2,
  input  logic [DATA_WIDTH-1:0]     IMMEDIATE,
  input  logic [ALU_OP_WIDTH-1:0]   ALU_OP,
  input  logic                      BRANCH_JUMP,
  input  logic                      OP1_SEL,
  input  logic                      OP2_SEL,
  input  logic [1:0]                MEM_WRITE,
  input  logic [1:0]                MEM_READ,
  input  logic [1:0]                REG_WRITE_SEL,
  input  logic                      REG_WRITE_ENABLE,
  output logic [REG_ADDR_WIDTH-1:0] OUT_DEST_REG,
  output logic [DATA_WIDTH-1:0]     OUT_PC_PLUS_4,
  output logic [DATA_WIDTH-1:0]     OUT_READ_DATA1,
  output logic [DATA_WIDTH-1:0]     OUT_READ_DATA2,
  output logic [DATA_WIDTH-1:0]     OUT_IMMEDIATE,
  output logic [ALU_OP_WIDTH-1:0]   OUT_ALU_OP,
  output logic                      OUT_BRANCH_JUMP,
  output logic                      OUT_OP1_SEL,
  output logic                      OUT_OP2_SEL,
  output logic [1:0]                OUT_MEM_WRITE,
  output logic [1:0]                OUT_MEM_READ,
  output logic [1:0]                OUT_REG_WRITE_SEL,
  output logic                      OUT_REG_WRITE_ENABLE
);

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] dest_reg;
    logic [DATA_WIDTH-1:0]     pc_plus_4;
    logic [DATA_WIDTH-1:0]     read_data1;
    logic [DATA_WIDTH-1:0]     read_data2;
    logic [DATA_WIDTH-1:0]     immediate;
    logic [ALU_OP_WIDTH-1:0]   alu_op;
    logic                      branch_jump;
    logic                      op1_sel;
    logic                      op2_sel;
    logic [1:0]                mem_write;
    logic [1:0]                mem_read;
    logic [1:0]                reg_write_sel;
    logic                      reg_write_enable;
  } stage_t;

  stage_t stage_in;
  stage_t stage_d;
  stage_t stage_q;

  assign stage_in = '{
    dest_reg:         DEST_REG,
    pc_plus_4:        PC_PLUS_4,
    read_data1:       READ_DATA1,
    read_data2:       READ_DATA2,
    immediate:        IMMEDIATE,
    alu_op:           ALU_OP,
    branch_jump:      BRANCH_JUMP,
    op1_sel:          OP1_SEL,
    op2_sel:          OP2_SEL,
    mem_write:        MEM_WRITE,
    mem_read:         MEM_READ,
    reg_write_sel:    REG_WRITE_SEL,
    reg_write_enable: REG_WRITE_ENABLE
  };

  // An all-zero stage is a NOP: no register write, no memory access, no branch.
  // FLUSH wins over STALL so a squashed instruction never lingers in EX.
  always_comb begin
    stage_d = stage_q;
    if (FLUSH) begin
      stage_d = '0;
    end else if (!STALL) begin
      stage_d = stage_in;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign OUT_DEST_REG         = stage_q.dest_reg;
  assign OUT_PC_PLUS_4        = stage_q.pc_plus_4;
  assign OUT_READ_DATA1       = stage_q.read_data1;
  assign OUT_READ_DATA2       = stage_q.read_data2;
  assign OUT_IMMEDIATE        = stage_q.immediate;
  assign OUT_ALU_OP           = stage_q.alu_op;
  assign OUT_BRANCH_JUMP      = stage_q.branch_jump;
  assign OUT_OP1_SEL          = stage_q.op1_sel;
  assign OUT_OP2_SEL          = stage_q.op2_sel;
  assign OUT_MEM_WRITE        = stage_q.mem_write;
  assign OUT_MEM_READ         = stage_q.mem_read;
  assign OUT_REG_WRITE_SEL    = stage_q.reg_write_sel;
  assign OUT_REG_WRITE_ENABLE = stage_q.reg_write_enable;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// Directed bench for id_ex_pipeline_reg: drivers push hand-computed expected
// output bundles into a queue; a monitor pops and compares on each sample request.
module tb_id_ex_pipeline_reg;

  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int AW  = 5;
  localparam int BW  = RW + 4 * DW + AW + 1 + 1 + 1 + 2 + 2 + 2 + 1;

  // Bundle order: dest, pc4, rd1, rd2, imm, alu_op, bj, op1, op2, mw, mr, rws, rwe
  localparam logic [BW-1:0] SET_ZERO = '0;
  localparam logic [BW-1:0] SET_A = {5'd1, 32'd104, 32'd42, 32'd84, 32'd100, 5'd2,
                                     1'b1, 1'b1, 1'b0, 2'b01, 2'b10, 2'b11, 1'b1};
  localparam logic [BW-1:0] SET_B = {5'd2, 32'd204, 32'd200, 32'd400, 32'd300, 5'd3,
                                     1'b0, 1'b0, 1'b1, 2'b10, 2'b01, 2'b00, 1'b0};
  localparam logic [BW-1:0] SET_C = {5'd31, 32'hFFFF_FFFC, 32'h8000_0000, 32'hDEAD_BEEF,
                                     32'hFFFF_F800, 5'd31, 1'b1, 1'b1, 1'b1, 2'b11,
                                     2'b11, 2'b10, 1'b1};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          stall, flush;
  logic [RW-1:0] dest_reg;
  logic [DW-1:0] pc_plus_4, read_data1, read_data2, immediate;
  logic [AW-1:0] alu_op;
  logic          branch_jump, op1_sel, op2_sel;
  logic [1:0]    mem_write, mem_read, reg_write_sel;
  logic          reg_write_enable;

  logic [RW-1:0] out_dest_reg;
  logic [DW-1:0] out_pc_plus_4, out_read_data1, out_read_data2, out_immediate;
  logic [AW-1:0] out_alu_op;
  logic          out_branch_jump, out_op1_sel, out_op2_sel;
  logic [1:0]    out_mem_write, out_mem_read, out_reg_write_sel;
  logic          out_reg_write_enable;

  id_ex_pipeline_reg #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RW), .ALU_OP_WIDTH(AW)
  ) dut (
    .CLK(clk), .RESET(rst_n), .STALL(stall), .FLUSH(flush),
    .DEST_REG(dest_reg), .PC_PLUS_4(pc_plus_4), .READ_DATA1(read_data1),
    .READ_DATA2(read_data2), .IMMEDIATE(immediate), .ALU_OP(alu_op),
    .BRANCH_JUMP(branch_jump), .OP1_SEL(op1_sel), .OP2_SEL(op2_sel),
    .MEM_WRITE(mem_write), .MEM_READ(mem_read), .REG_WRITE_SEL(reg_write_sel),
    .REG_WRITE_ENABLE(reg_write_enable),
    .OUT_DEST_REG(out_dest_reg), .OUT_PC_PLUS_4(out_pc_plus_4),
    .OUT_READ_DATA1(out_read_data1), .OUT_READ_DATA2(out_read_data2),
    .OUT_IMMEDIATE(out_immediate), .OUT_ALU_OP(out_alu_op),
    .OUT_BRANCH_JUMP(out_branch_jump), .OUT_OP1_SEL(out_op1_sel),
    .OUT_OP2_SEL(out_op2_sel), .OUT_MEM_WRITE(out_mem_write),
    .OUT_MEM_READ(out_mem_read), .OUT_REG_WRITE_SEL(out_reg_write_sel),
    .OUT_REG_WRITE_ENABLE(out_reg_write_enable)
  );

  logic [BW-1:0] dut_out;
  assign dut_out = {out_dest_reg, out_pc_plus_4, out_read_data1, out_read_data2,
                    out_immediate, out_alu_op, out_branch_jump, out_op1_sel,
                    out_op2_sel, out_mem_write, out_mem_read, out_reg_write_sel,
                    out_reg_write_enable};

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  string         name_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  event          chk_ev;

  always begin
    logic [BW-1:0] exp_v;
    string         nm;
    @(chk_ev);
    while (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      n_checks++;
      if (dut_out !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", nm, dut_out, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [BW-1:0] v);
    {dest_reg, pc_plus_4, read_data1, read_data2, immediate, alu_op, branch_jump,
     op1_sel, op2_sel, mem_write, mem_read, reg_write_sel, reg_write_enable} = v;
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [BW-1:0] v, input string nm);
    exp_q.push_back(v);
    name_q.push_back(nm);
    -> chk_ev;
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    drive(SET_A);
    #1;
    expect_out(SET_ZERO, "rst_initial");
    cycle(); expect_out(SET_ZERO, "rst_hold_edge1");
    cycle(); expect_out(SET_ZERO, "rst_hold_edge2");

    @(negedge clk); rst_n = 1'b1;
    cycle(); expect_out(SET_A, "load_a");

    @(negedge clk); drive(SET_B);
    #1 expect_out(SET_A, "pre_edge_b");
    cycle(); expect_out(SET_B, "load_b");

    @(negedge clk); drive(SET_A);
    cycle(); expect_out(SET_A, "reload_a");
    @(negedge clk); stall = 1'b1; drive(SET_B);
    for (int i = 0; i < 3; i++) begin
      cycle(); expect_out(SET_A, $sformatf("stall_%0d", i));
    end
    @(negedge clk); stall = 1'b0;
    cycle(); expect_out(SET_B, "unstall_b");

    @(negedge clk); drive(SET_A);
    cycle(); expect_out(SET_A, "pre_flush_a");
    @(negedge clk); flush = 1'b1; stall = 1'b1; drive(SET_B);
    cycle(); expect_out(SET_ZERO, "flush_over_stall");
    @(negedge clk); flush = 1'b0; stall = 1'b0;
    cycle(); expect_out(SET_B, "post_flush_b");

    @(negedge clk); drive(SET_C);
    #1 expect_out(SET_B, "between_edges_1");
    drive(SET_A);
    #1 expect_out(SET_B, "between_edges_2");
    drive(SET_C);
    cycle(); expect_out(SET_C, "load_c_extremes");

    @(negedge clk); flush = 1'b1;
    cycle(); expect_out(SET_ZERO, "flush_alone");
    @(negedge clk); flush = 1'b0; drive(SET_A);
    cycle(); expect_out(SET_A, "load_a_again");

    #2 rst_n = 1'b0;
    #1 expect_out(SET_ZERO, "async_reset_mid_cycle");
    cycle(); expect_out(SET_ZERO, "reset_ignores_edge");
    @(negedge clk); rst_n = 1'b1; drive(SET_B);
    cycle(); expect_out(SET_B, "first_capture");

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d pending checks, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
